load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side memory access unit between the RV32 core's execute stage and the word-wide, big-endian data memory. It accepts one load or store request at a time over a valid/ready handshake and handles LB/LBU/LH/LHU/LW/SB/SH/SW sizing. Sub-word stores are done as a read-modify-write because the memory write port is word-only. Alignment and range faults are flagged without touching memory.

## Interface
- MEM_BYTES, 1024, data memory size in bytes; word-aligned addresses above MEM_BYTES-4 fault
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; returns FSM to IDLE and clears all outputs immediately
- req_valid  in  1  core presents a request
- req_ready  out  1  high only in IDLE; request accepted on posedge when req_valid && req_ready
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 zero-extends, 0 sign-extends (ignored for word and stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and faults
- resp_fault  out  1  qualified by resp_valid; misaligned, illegal size or out of range
- access_mem_addr  out  32  word-aligned memory address, {addr[31:2],2'b00}
- write_mem_data  out  32  merged word to write
- mem_write_en  out  1  memory write strobe; the memory writes on the posedge ending the cycle
- mem_read  out  1  memory read enable
- read_mem_data  in  32  combinational read word; byte at offset k occupies bits [31-8k : 24-8k]

## Operation
- States: IDLE, READ, WRITE, RESP. Moore outputs.
- On acceptance, addr, size, store, unsigned and wdata are latched.
- Fault check at acceptance:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - aligned address > MEM_BYTES-4
- Transitions out of IDLE:
  - fault → RESP
  - load or sub-word store → READ
  - word store → WRITE
- READ: mem_read=1, access_mem_addr=aligned address; read_mem_data is captured into an internal word buffer at the posedge. Next state is RESP for a load, WRITE for a store.
- WRITE: mem_write_en=1.
  - Word store: write_mem_data = latched wdata.
  - SB: buffer with byte lane k (k = addr[1:0]) replaced by wdata[7:0].
  - SH: offset 0 replaces [31:16] with wdata[15:0]; offset 2 replaces [15:0].
  - Next state RESP.
- RESP: resp_valid=1. resp_rdata is the extracted lane (byte lane k, or half [31:16]/[15:0] by addr[1]), sign- or zero-extended to 32 bits; a word load returns the whole buffer. Stores and faults return 0. Next state IDLE.
- Outside READ/WRITE, mem_read, mem_write_en, access_mem_addr and write_mem_data are 0. Memory is never strobed on a fault.
- req_valid is ignored while busy. The core must hold request fields until acceptance.
- resp_rdata and resp_fault are registered and hold their value until the next RESP.

## Timing
- Reset values: state IDLE, req_ready 1, all other outputs 0, buffer 0.
- Latency measured from the acceptance edge (resp_valid high in the Nth cycle after):
  - fault: 1
  - load: 2
  - word store: 2
  - sub-word store: 3
- Throughput: the next request is accepted in IDLE, the cycle after RESP, so there is no back-to-back overlap.
- Reset asserted mid-operation drops mem_write_en and mem_read combinationally (async). No partial or late write occurs, and no resp_valid is produced for the aborted request.

## Test plan
- LW addr 4, memory bytes 4..7 = 00 00 00 0C → mem_read=1 and access_mem_addr=4 in cycle 1 only; resp_valid in cycle 2, resp_rdata=0x0000000C, resp_fault=0.
- Byte 7=0x80, bytes 4..7 = 00 00 01 80:
  - LB 7 → 0xFFFFFF80
  - LBU 7 → 0x00000080
  - LH 6 → 0x00000180
  - LHU 6 with bytes 6..7 = 80 01 → 0x00008001
- Word at 8 = 0x11223344:
  - SB 9, wdata 0x000000AB → READ at 8, then one WRITE cycle with write_mem_data=0x11AB3344; resp at cycle 3
  - SH 10, wdata 0xBEEF → 0x1122BEEF
- SW 8, wdata 0xDEADBEEF → mem_read never high; mem_write_en in cycle 1 with 0xDEADBEEF at addr 8; resp cycle 2, resp_rdata=0.
- Faults, each giving resp_valid in cycle 1 with resp_fault=1, resp_rdata=0 and no memory strobes:
  - LW 6
  - LH 3
  - SW 1024
  - size 11
- SH 10 with reset pulsed during READ → all outputs 0 immediately, memory word unchanged, req_ready=1 after release; a following LW 8 returns the original value.

Source files
------------

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit
// Initiator-side memory access unit between the RV32 execute stage and a
// word-wide, big-endian data memory. Accepts one load/store at a time over a
// valid/ready handshake and handles byte/half/word sizing. Sub-word stores
// are read-modify-write because the memory write port is word-only.
// Misaligned, illegal-size and out-of-range requests fault without touching
// memory.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only when idle)
//   req_store, req_size,     request fields, held by the core until accepted
//   req_unsigned, req_addr,
//   req_wdata
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_fault   registered result, held until the next response
//   access_mem_addr          word-aligned memory address (0 when idle)
//   write_mem_data           merged word to write (0 outside a write)
//   mem_write_en, mem_read   memory strobes
//   read_mem_data            combinational memory read word
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] access_mem_addr,
  output logic [31:0] write_mem_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [31:0] read_mem_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_store;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_resp_rdata;
  logic        r_resp_fault;

  logic        w_accept;
  logic        w_req_fault;
  logic [31:0] w_aligned;
  logic [31:0] w_merged;
  logic [31:0] w_load_data;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_aligned = {r_addr[31:2], 2'b00};

  // Faults are judged on the live request fields at the acceptance edge.
  assign w_req_fault = (req_size == 2'b11)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                    || ({req_addr[31:2], 2'b00} > LAST_WORD);

  // Lane extraction from a big-endian word: byte k lives in [31-8k:24-8k].
  function automatic logic [31:0] extract_lane(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign w_load_data = extract_lane(read_mem_data, r_size, r_addr[1:0], r_unsigned);

  // Merge the store data into the word read back during READ.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_merged = r_buf;
    case (r_size)
      SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0:    w_merged[31:24] = r_wdata[7:0];
          2'd1:    w_merged[23:16] = r_wdata[7:0];
          2'd2:    w_merged[15:8]  = r_wdata[7:0];
          default: w_merged[7:0]   = r_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (r_addr[1]) w_merged[15:0]  = r_wdata[15:0];
        else           w_merged[31:16] = r_wdata[15:0];
      end
      default: w_merged = r_wdata;
    endcase
  end

  // State register. Reset is asynchronous so the memory strobes, which are
  // decoded from state, drop the moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_next_state    = r_state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_read        = 1'b0;
    mem_write_en    = 1'b0;
    access_mem_addr = 32'h0;
    write_mem_data  = 32'h0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_req_fault)                             w_next_state = S_RESP;
          else if (req_store && (req_size == SZ_WORD)) w_next_state = S_WRITE;
          else                                         w_next_state = S_READ;
        end
      end
      S_READ: begin
        mem_read        = 1'b1;
        access_mem_addr = w_aligned;
        w_next_state    = r_store ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_write_en    = 1'b1;
        access_mem_addr = w_aligned;
        write_mem_data  = w_merged;
        w_next_state    = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request latch, read buffer and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the buffer is a single word register, not a memory array, so
      // clearing it on reset is cheap and keeps every output well defined.
      r_addr       <= 32'h0;
      r_size       <= 2'b00;
      r_store      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_wdata      <= 32'h0;
      r_buf        <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr;
        r_size     <= req_size;
        r_store    <= req_store;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
      end
      if (r_state == S_READ) r_buf <= read_mem_data;
      // Response registers change only on the edge entering RESP so they hold
      // across the whole gap between responses. Only a fault reaches RESP
      // straight from IDLE; only a load reaches it from READ.
      if (w_next_state == S_RESP) begin
        r_resp_fault <= (r_state == S_IDLE);
        r_resp_rdata <= (r_state == S_READ) ? w_load_data : 32'h0;
      end
    end
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_fault = r_resp_fault;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Self-checking bench for load_store_unit: directed scenarios followed by
// randomized requests, compared cycle by cycle against a byte-array memory
// model that applies the big-endian sizing rules directly.
module tb_load_store_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] access_mem_addr;
  logic [31:0] write_mem_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [31:0] read_mem_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault),
    .access_mem_addr (access_mem_addr),
    .write_mem_data  (write_mem_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .read_mem_data   (read_mem_data)
  );

  // Word-wide data memory seen by the DUT, with a bench-side preload port.
  logic [31:0] mem_words [MEM_BYTES/4];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign read_mem_data = mem_words[access_mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write_en)  mem_words[access_mem_addr[9:2]] <= write_mem_data;
    else if (pl_en)    mem_words[pl_idx] <= pl_data;
  end

  // Reference memory: plain byte array, big-endian within a word.
  logic [7:0] ref_mem [MEM_BYTES];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  function automatic bit ref_fault(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'b11) return 1'b1;
    n = 1 << size;
    if ((addr % n) != 0) return 1'b1;
    if ((addr & ~32'd3) > 32'(MEM_BYTES - 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
    int n = 1 << size;
    logic [63:0] v = 64'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[int'(addr) + i]);
    if (!uns && n < 4 && v[8*n-1]) v = v | (~64'h0 << (8*n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int n = 1 << size;
    for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*(n-1-i) +: 8];
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = 8'(a >> 2);
    pl_data = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[a + k] = v[31-8*k -: 8];
  endtask

  // Issue one request and check every cycle until one idle cycle after the
  // response.
  task automatic do_req(input string tag, input logic store, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    bit          fault;
    bit          word_store;
    int          lat;
    int          aligned;
    bit          exp_rd;
    bit          exp_wr;
    int          guard;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] exp_wdata = 32'h0;

    fault      = ref_fault(size, addr);
    word_store = store && (size == 2'b10);
    lat        = fault ? 1 : (store ? (word_store ? 2 : 3) : 2);
    aligned    = int'(addr & ~32'd3);
    if (!fault && !store) exp_rdata = ref_load(size, uns, addr);
    if (!fault && store) begin
      ref_store(size, addr, wdata);
      exp_wdata = ref_word(aligned);
    end

    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, req_ready, 1'b1);

    req_valid    = 1'b1;
    req_store    = store;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    // Scramble the fields after acceptance to prove they were latched.
    req_valid    = 1'b0;
    req_store    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;

    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      exp_rd = !fault && !word_store && (c == 1);
      exp_wr = store && !fault && (c == lat - 1);
      check({tag, " mem_read"},     mem_read,        exp_rd);
      check({tag, " mem_write_en"}, mem_write_en,    exp_wr);
      check({tag, " resp_valid"},   resp_valid,      c == lat);
      check({tag, " req_ready"},    req_ready,       c > lat);
      check({tag, " mem_addr"},     access_mem_addr, (exp_rd || exp_wr) ? 32'(aligned) : 32'h0);
      check({tag, " wdata"},        write_mem_data,  exp_wr ? exp_wdata : 32'h0);
      if (c >= lat) begin
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " fault"}, resp_fault, fault);
      end
    end
    if (store && !fault) check({tag, " memword"}, mem_words[aligned >> 2], ref_word(aligned));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_store    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    #1;
    check("rst req_ready",  req_ready,       1'b1);
    check("rst resp_valid", resp_valid,      1'b0);
    check("rst rdata",      resp_rdata,      32'h0);
    check("rst fault",      resp_fault,      1'b0);
    check("rst mem_read",   mem_read,        1'b0);
    check("rst mem_we",     mem_write_en,    1'b0);
    check("rst mem_addr",   access_mem_addr, 32'h0);
    check("rst wdata",      write_mem_data,  32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < MEM_BYTES; i += 4) preload(i, $urandom);

    // Loads and sign/zero extension.
    preload(4, 32'h0000000C);
    do_req("LW 4", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    preload(4, 32'h00000180);
    do_req("LB 7",  1'b0, 2'b00, 1'b0, 32'd7, 32'h0);
    do_req("LBU 7", 1'b0, 2'b00, 1'b1, 32'd7, 32'h0);
    do_req("LH 6",  1'b0, 2'b01, 1'b0, 32'd6, 32'h0);
    preload(4, 32'h00008001);
    do_req("LHU 6", 1'b0, 2'b01, 1'b1, 32'd6, 32'h0);
    do_req("LH 6 neg", 1'b0, 2'b01, 1'b0, 32'd6, 32'h0);

    // Stores, including read-modify-write.
    preload(8, 32'h11223344);
    do_req("SB 9", 1'b1, 2'b00, 1'b0, 32'd9, 32'h000000AB);
    check("SB 9 value", mem_words[2], 32'h11AB3344);
    preload(8, 32'h11223344);
    do_req("SH 10", 1'b1, 2'b01, 1'b0, 32'd10, 32'h0000BEEF);
    check("SH 10 value", mem_words[2], 32'h1122BEEF);
    do_req("SW 8", 1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF);
    check("SW 8 value", mem_words[2], 32'hDEADBEEF);

    // Faults and the top-of-memory boundary.
    do_req("F LW 6",    1'b0, 2'b10, 1'b0, 32'd6,    32'h0);
    do_req("F LH 3",    1'b0, 2'b01, 1'b0, 32'd3,    32'h0);
    do_req("F SW 1024", 1'b1, 2'b10, 1'b0, 32'd1024, 32'h12345678);
    do_req("F size11",  1'b0, 2'b11, 1'b0, 32'd8,    32'h0);
    do_req("F SB 1024", 1'b1, 2'b00, 1'b0, 32'd1024, 32'h5A);
    do_req("LW 1020",   1'b0, 2'b10, 1'b0, 32'd1020, 32'h0);
    do_req("SB 1023",   1'b1, 2'b00, 1'b0, 32'd1023, 32'hC3);

    // Reset pulsed while a sub-word store sits in READ.
    preload(8, 32'h11223344);
    @(negedge clk);
    check("abort ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_size  = 2'b01;
    req_addr  = 32'd10;
    req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort in READ", mem_read, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("abort mem_read",   mem_read,        1'b0);
    check("abort mem_we",     mem_write_en,    1'b0);
    check("abort mem_addr",   access_mem_addr, 32'h0);
    check("abort wdata",      write_mem_data,  32'h0);
    check("abort resp_valid", resp_valid,      1'b0);
    check("abort rdata",      resp_rdata,      32'h0);
    check("abort fault",      resp_fault,      1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort ready after", req_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort no resp",  resp_valid,   1'b0);
      check("abort no write", mem_write_en, 1'b0);
    end
    check("abort memword", mem_words[2], 32'h11223344);
    do_req("LW 8 after abort", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0);

    // Randomized mix of sizes, directions and addresses.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = (($urandom % 8) == 0) ? $urandom : ($urandom % MEM_BYTES);
      do_req("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
